// File: rtl/ysyx_040729_pkg.sv
// Shared definitions for the EXE-stage integer divider: opcode encodings and
// controller state encodings.
package ysyx_040729_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ysyx_040729_div_step.sv
// One restoring shift-subtract iteration: shifts {rem,quo} left by one and
// subtracts the divisor magnitude from the partial remainder when it fits.
module ysyx_040729_div_step
    import ysyx_040729_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder can reach 2*|divisor|-1, so it needs one extra bit;
    // the borrow out of the widened subtraction doubles as the "does not fit" flag.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          take;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_i};
    assign take   = ~diff[XLEN];
    assign rem_o  = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_o  = {quo_i[XLEN-2:0], take};

endmodule

// File: rtl/ysyx_040729_exe_div_ctrl.sv
// Sequencing controller for the EXE-stage radix-2 restoring divider
// (RV64M DIV/DIVU/REM/REMU and *W variants), one quotient bit per cycle.
module ysyx_040729_exe_div_ctrl
    import ysyx_040729_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v,
                                                 input logic word, input logic sgn);
        if (!word) return v;
        return sgn ? sext32(v) : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fix_result(input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] r,
                                                   input logic neg_q, input logic neg_r,
                                                   input logic is_rem, input logic word);
        logic [XLEN-1:0] res;
        res = is_rem ? cond_neg(r, neg_r) : cond_neg(q, neg_q);
        return word ? sext32(res) : res;
    endfunction

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            isrem_q, isrem_d;
    logic            word_q, word_d;

    // Operand preparation for the request currently on the input port
    logic            sgn_in;
    logic            isrem_in;
    logic [XLEN-1:0] a_ext, b_ext;
    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] min_val;
    logic            div0, ovf;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign sgn_in   = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    assign isrem_in = (op_i == DIV_OP_REM) || (op_i == DIV_OP_REMU);
    assign a_ext    = word_ext(dividend_i, word_i, sgn_in);
    assign b_ext    = word_ext(divisor_i, word_i, sgn_in);
    assign sa       = sgn_in & a_ext[XLEN-1];
    assign sb       = sgn_in & b_ext[XLEN-1];
    assign abs_a    = cond_neg(a_ext, sa);
    assign abs_b    = cond_neg(b_ext, sb);
    assign min_val  = word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div0     = (b_ext == '0);
    assign ovf      = sgn_in && (a_ext == min_val) && (b_ext == '1);

    always_comb begin
        special_res = '0;
        if (div0) begin
            special_res = isrem_in ? a_ext : '1;
        end else if (ovf) begin
            special_res = isrem_in ? '0 : a_ext;
        end
        if (word_i) begin
            special_res = sext32(special_res);
        end
    end

    logic [XLEN-1:0] step_rem, step_quo;
    logic [CNT_W-1:0] last_cnt;

    ysyx_040729_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign last_cnt = word_q ? CNT_W'(31) : CNT_W'(XLEN-1);
    assign accept   = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        isrem_d  = isrem_q;
        word_d   = word_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d  = word_i;
                    isrem_d = isrem_in;
                    negq_d  = sa ^ sb;
                    negr_d  = sa;
                    dvs_d   = abs_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    // *W dividends start in the upper half so 32 shifts consume them fully
                    quo_d   = word_i ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                    if (div0 || ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    result_d = fix_result(step_quo, step_rem, negq_q, negr_q, isrem_q, word_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            isrem_q  <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            isrem_q  <= isrem_d;
            word_q   <= word_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;

endmodule
